// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the fetch PC unit.
package pc_pkg;
  localparam int          XLEN_DEF       = 32;
  localparam int          INST_BYTES_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_RAS,
    SEL_JUMP,
    SEL_SEQ
  } next_pc_sel_t;
endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bus of the PC unit: decode/execute steering in, PC and RAS status out.
interface pc_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            is_update;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_jump;
  logic [XLEN-1:0] dec_target;
  logic            dec_call;
  logic [XLEN-1:0] dec_ret_addr;
  logic            dec_ret;
  logic [XLEN-1:0] current_pc;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_count;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output is_update, redirect_valid, redirect_pc, dec_jump, dec_target,
           dec_call, dec_ret_addr, dec_ret,
    input  current_pc, ras_top, ras_count, ras_empty, ras_full
  );

  modport slave (
    input  is_update, redirect_valid, redirect_pc, dec_jump, dec_target,
           dec_call, dec_ret_addr, dec_ret,
    output current_pc, ras_top, ras_count, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [XLEN-1:0]              push_data,
  output logic [XLEN-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [RAS_DEPTH-1:0][XLEN-1:0] entries;
  logic [PW-1:0]                  tp;
  logic                           empty;

  assign empty = (count == '0);
  // Popped entries stay in storage, so the visible top must be masked when empty.
  assign top   = empty ? '0 : entries[tp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp      <= '0;
      count   <= '0;
      entries <= '0;
    end else if (push && pop && !empty) begin
      entries[tp] <= push_data;
    end else if (push) begin
      tp                    <= tp + PW'(1);
      entries[tp + PW'(1)]  <= push_data;
      if (count != CW'(RAS_DEPTH)) count <= count + CW'(1);
    end else if (pop && !empty) begin
      tp    <= tp - PW'(1);
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised next-PC selection and return-address prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter int              INST_BYTES = INST_BYTES_DEF,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  next_pc_sel_t    sel;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_count;
  logic            ras_empty;
  logic            ras_op_en;

  // A redirect marks this cycle's decode outputs as wrong-path, so the RAS is left alone.
  assign ras_op_en = bus.is_update && !bus.redirect_valid;
  assign ras_empty = (ras_count == '0);

  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_op_en && bus.dec_call),
    .pop       (ras_op_en && bus.dec_ret),
    .push_data (bus.dec_ret_addr),
    .top       (ras_top),
    .count     (ras_count)
  );

  always_comb begin
    sel = SEL_SEQ;
    if (bus.redirect_valid)                 sel = SEL_REDIRECT;
    else if (!bus.is_update)                sel = SEL_HOLD;
    else if (bus.dec_ret && !ras_empty)     sel = SEL_RAS;
    else if (bus.dec_jump)                  sel = SEL_JUMP;
  end

  always_comb begin
    next_pc = bus.current_pc + XLEN'(INST_BYTES);
    case (sel)
      SEL_REDIRECT: next_pc = bus.redirect_pc;
      SEL_HOLD:     next_pc = bus.current_pc;
      SEL_RAS:      next_pc = ras_top;
      SEL_JUMP:     next_pc = bus.dec_target;
      default:      next_pc = bus.current_pc + XLEN'(INST_BYTES);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.current_pc <= RESET_PC;
    else       bus.current_pc <= next_pc;
  end

  assign bus.ras_top   = ras_top;
  assign bus.ras_count = ras_count;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = (ras_count == CW'(RAS_DEPTH));
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit with next-PC selection and an integrated return-address stack (RAS). It replaces the plain single-register PC at the head of the fetch path. It holds the fetch PC, advances it sequentially, accepts decode-stage jump and return predictions, and takes execute-stage redirects. The RAS lets function returns be predicted without waiting for register read.

## Interface

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_PC, 0, value loaded into current_pc on reset.
- INST_BYTES, 4, sequential increment.
- RAS_DEPTH, 4, number of RAS entries; power of two, 2 to 16.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
- is_update  in  1  advance enable; 0 = stall, hold PC and RAS.
- redirect_valid  in  1  execute-stage redirect (branch mispredict or indirect jump).
- redirect_pc  in  XLEN  redirect target.
- dec_jump  in  1  decode: direct jump predicted taken.
- dec_target  in  XLEN  decode: direct jump target.
- dec_call  in  1  decode: call; push dec_ret_addr.
- dec_ret_addr  in  XLEN  return address to push, i.e. call PC + INST_BYTES.
- dec_ret  in  1  decode: return; pop RAS and predict its top.
- current_pc  out  XLEN  registered fetch PC.
- ras_top  out  XLEN  entry at top of stack; 0 when empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries.
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == RAS_DEPTH.

## Operation

Next-PC priority, highest first:
1. reset → RESET_PC.
2. redirect_valid → redirect_pc. This applies even when is_update = 0. All dec_* inputs are ignored this cycle as wrong-path.
3. is_update = 0 → hold current_pc.
4. dec_ret with RAS not empty → ras_top.
5. dec_jump → dec_target.
6. Otherwise → current_pc + INST_BYTES, modulo 2^XLEN; wrap from all-ones is legal.

RAS, a circular buffer with top pointer tp and count:
- RAS operations happen only when is_update = 1 and redirect_valid = 0.
- Push only (dec_call):
  - tp advances, and entry[tp+1] is written with dec_ret_addr.
  - count saturates at RAS_DEPTH.
  - Push while full overwrites the oldest entry, because the pointer wraps modulo RAS_DEPTH.
- Pop only (dec_ret):
  - If not empty, tp retreats and count decrements.
  - If empty, there is no state change and next PC falls through to the sequential/jump path (rule 5 or 6).
- dec_call and dec_ret together (pop-then-push):
  - entry[tp] is replaced with dec_ret_addr; tp and count are unchanged.
  - If the stack was empty, this acts as a plain push.
  - Next PC still uses the old ras_top when the stack was non-empty.
- dec_jump and dec_ret together: the RAS prediction wins when non-empty.
- A redirect does not repair the RAS; recovery is out of scope.
- Entry storage is not cleared on pop; ras_top is forced to 0 when empty.

## Timing

- Reset values: current_pc = RESET_PC, tp = 0, count = 0, all entries 0, ras_top = 0, ras_empty = 1, ras_full = 0.
- current_pc, tp, count and entries are registers. The next-PC selection is visible on current_pc one cycle after inputs are sampled.
- ras_top, ras_empty and ras_full are combinational from registered state and reflect the post-edge stack.
- Reset asserted mid-operation forces reset values asynchronously. The first update after deassertion occurs at the first rising edge with reset low.
- There is no combinational path from dec_* or redirect_* inputs to any output.

## Structure

- Shared package pc_pkg holds:
  - Default constants XLEN_DEF, INST_BYTES_DEF, RESET_PC_DEF.
  - An enum next_pc_sel_t {SEL_RESET, SEL_REDIRECT, SEL_HOLD, SEL_RAS, SEL_JUMP, SEL_SEQ} used by the selector and by bench coverage.
- One sub-module, ras_stack (parameters XLEN and RAS_DEPTH; ports push, pop, push_data, top, count), owns the circular buffer and its pointer/count arithmetic.
- pc_unit keeps the PC register and the priority selector.

## Test plan

- Reset and sequential fetch: reset high, then 3 cycles with is_update = 1 → current_pc = 0x0, 0x4, 0x8, 0xC; RESET_PC = 0x100 gives 0x100, 0x104.
- Stall and redirect priority:
  - Hold is_update = 0 for 2 cycles → PC unchanged.
  - Assert redirect_valid with redirect_pc = 0x400, is_update = 0, and dec_call = 1 → PC = 0x400 next cycle; ras_count stays 0.
- Call/return:
  - dec_call with dec_ret_addr = 0x20 and dec_jump to 0x80 → PC = 0x80, ras_top = 0x20, count = 1.
  - Then dec_ret → PC = 0x20, count = 0, ras_empty = 1.
- Overflow: 5 pushes of 0x10, 0x20, 0x30, 0x40, 0x50 into RAS_DEPTH = 4 → count = 4, ras_full = 1. Four pops predict 0x50, 0x40, 0x30, 0x20, then empty.
- Underflow and simultaneous ops:
  - dec_ret on empty stack at PC 0x8 → PC = 0xC, count stays 0.
  - With top 0x20, dec_call (0x90) and dec_ret together → PC = 0x20, ras_top = 0x90, count unchanged.
- Wrap and async reset:
  - PC at 0xFFFFFFFC sequential → 0x0.
  - Assert reset between clock edges → current_pc = RESET_PC before the next edge, count = 0.
